// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: command/opcode constants and state types shared by the UART ALU
package uart_alu_pkg;
  localparam logic [7:0] CMD_LOAD_A  = 8'h01;
  localparam logic [7:0] CMD_LOAD_B  = 8'h02;
  localparam logic [7:0] CMD_LOAD_OP = 8'h03;
  localparam logic [7:0] CMD_EXEC    = 8'h04;
  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_SRL = 8'h02;
  typedef enum logic [2:0] {C_IDLE, C_WAIT_A, C_WAIT_B, C_WAIT_OP, C_EXEC} cmd_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_ARM, T_START, T_DATA, T_STOP} tx_state_t;
endpackage

// File: rtl/uart_alu_alu.sv
// uart_alu_alu: combinational MIPS-funct ALU; shifts only built when SHIFT_OPS_EN is defined
module uart_alu_alu import uart_alu_pkg::*; #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] op,
  output logic [N-1:0] result
);
  // results wrap mod 2^N; unknown opcodes give zero
  always_comb begin
    result = '0;
    case (op)
      N'(OP_ADD): result = a + b;
      N'(OP_SUB): result = a - b;
      N'(OP_AND): result = a & b;
      N'(OP_OR):  result = a | b;
      N'(OP_XOR): result = a ^ b;
      N'(OP_NOR): result = ~(a | b);
`ifdef SHIFT_OPS_EN
      N'(OP_SRA): result = $signed(a) >>> b;
      N'(OP_SRL): result = a >> b;
`endif
      default:    result = '0;
    endcase
  end
endmodule

// File: rtl/uart_alu_top.sv
// uart_alu_top: UART-controlled ALU (tick gen, RX, command FSM, TX); define SHIFT_OPS_EN for SRA/SRL
module uart_alu_top import uart_alu_pkg::*; #(
  parameter int N         = 8,
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic tx
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW  = N > 1 ? $clog2(N) : 1;
  logic [1:0] rst_sync;
  logic rst_n, tick, rx_m, rx_s, rx_q, rx_done, tx_start, tx_busy;
  logic [DW-1:0] tcnt;
  logic [3:0] r_tick, t_tick;
  logic [BW-1:0] r_bit, t_bit;
  logic [N-1:0] r_shift, rx_byte, t_shift, a, b, op, result;
  rx_state_t r_st;
  tx_state_t t_st;
  cmd_state_t st, nxt;
  // reset asserts asynchronously and releases on a clock edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  // free-running 16x oversampling tick
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= tcnt == DW'(DIV - 1);
      tcnt <= tcnt == DW'(DIV - 1) ? '0 : tcnt + 1'b1;
    end
  // two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rx_m, rx_s, rx_q} <= 3'b111;
    else {rx_m, rx_s, rx_q} <= {rx, rx_m, rx_s};
  // receiver: mid-bit sampling, glitch rejection on start, drop on bad stop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_st <= R_IDLE;
      r_tick <= '0;
      r_bit <= '0;
      r_shift <= '0;
      rx_byte <= '0;
      rx_done <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (r_st)
        R_IDLE: if (rx_q && !rx_s) begin
          r_st <= R_START;
          r_tick <= '0;
        end
        R_START: if (tick) begin
          r_tick <= r_tick + 4'd1;
          if (r_tick == 4'd7) begin
            r_st <= rx_s ? R_IDLE : R_DATA;
            r_tick <= '0;
            r_bit <= '0;
          end
        end
        R_DATA: if (tick) begin
          r_tick <= r_tick + 4'd1;
          if (r_tick == 4'd15) begin
            r_shift <= {rx_s, r_shift[N-1:1]};
            r_bit <= r_bit + 1'b1;
            if (r_bit == BW'(N - 1)) r_st <= R_STOP;
          end
        end
        R_STOP: if (tick) begin
          r_tick <= r_tick + 4'd1;
          if (r_tick == 4'd15) begin
            rx_done <= rx_s;
            rx_byte <= r_shift;
            r_st <= R_IDLE;
          end
        end
        default: r_st <= R_IDLE;
      endcase
    end
  // command FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= C_IDLE;
    else st <= nxt;
  // command FSM next state: wait states take the next byte whatever its value
  always_comb begin
    nxt = st;
    case (st)
      C_IDLE: if (rx_done)
        nxt = rx_byte == N'(CMD_LOAD_A)  ? C_WAIT_A  :
              rx_byte == N'(CMD_LOAD_B)  ? C_WAIT_B  :
              rx_byte == N'(CMD_LOAD_OP) ? C_WAIT_OP :
              rx_byte == N'(CMD_EXEC)    ? C_EXEC    : C_IDLE;
      C_EXEC: nxt = C_IDLE;
      default: if (rx_done) nxt = C_IDLE;
    endcase
  end
  // command FSM output: an execute while the transmitter is busy is dropped
  always_comb tx_start = st == C_EXEC && !tx_busy;
  // operand and opcode registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      op <= N'(OP_ADD);
    end else if (rx_done) begin
      if (st == C_WAIT_A) a <= rx_byte;
      if (st == C_WAIT_B) b <= rx_byte;
      if (st == C_WAIT_OP) op <= rx_byte;
    end
  uart_alu_alu #(.N(N)) u_alu (.a(a), .b(b), .op(op), .result(result));
  // transmitter: waits for a tick so every bit lasts exactly 16 ticks
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      t_st <= T_IDLE;
      t_tick <= '0;
      t_bit <= '0;
      t_shift <= '0;
      tx <= 1'b1;
    end else
      case (t_st)
        T_IDLE: if (tx_start) begin
          t_st <= T_ARM;
          t_shift <= result;
        end
        T_ARM: if (tick) begin
          t_st <= T_START;
          t_tick <= '0;
          tx <= 1'b0;
        end
        T_START: if (tick) begin
          t_tick <= t_tick + 4'd1;
          if (t_tick == 4'd15) begin
            t_st <= T_DATA;
            t_bit <= '0;
            tx <= t_shift[0];
            t_shift <= t_shift >> 1;
          end
        end
        T_DATA: if (tick) begin
          t_tick <= t_tick + 4'd1;
          if (t_tick == 4'd15) begin
            t_bit <= t_bit + 1'b1;
            tx <= t_bit == BW'(N - 1) ? 1'b1 : t_shift[0];
            t_shift <= t_shift >> 1;
            if (t_bit == BW'(N - 1)) t_st <= T_STOP;
          end
        end
        T_STOP: if (tick) begin
          t_tick <= t_tick + 4'd1;
          if (t_tick == 4'd15) t_st <= T_IDLE;
        end
        default: t_st <= T_IDLE;
      endcase
  assign tx_busy = t_st != T_IDLE;
endmodule

// File: tb/tb_uart_alu_top.sv
// tb_uart_alu_top: scoreboard bench for uart_alu_top at a fast baud (DIV=2, 32 clk per bit)
`timescale 1ns/1ps
module tb_uart_alu_top;
  localparam int CP = 20;
  localparam int BITC = 32;
`ifdef SHIFT_OPS_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif
  typedef struct {
    logic [7:0] d;
    bit ok;
  } frame_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic tx;
  int checks = 0;
  int errors = 0;
  int started = 0;
  int rst_cnt = 0;
  bit mon_busy = 1'b0;
  logic [7:0] exp_q[$];
  frame_t frames_q[$];

  uart_alu_top #(.N(8), .CLK_FREQ(50000000), .BAUD_RATE(1562500)) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx));

  always #(CP/2) clk = ~clk;
  always @(negedge reset) rst_cnt++;

  // frame decoder: samples each bit near its start, middle and end
  initial begin : mon
    time t0, d;
    int rc;
    logic s0, s1, s2;
    frame_t f;
    bit abort;
    @(posedge reset);
    forever begin
      @(negedge tx);
      t0 = $time;
      rc = rst_cnt;
      started++;
      mon_busy = 1'b1;
      abort = 1'b0;
      f.d = '0;
      f.ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
        if (!abort) begin
          d = t0 + (BITC*i + 2)*CP + 1 - $time;
          #d s0 = tx;
          d = t0 + (BITC*i + BITC/2)*CP + 1 - $time;
          #d s1 = tx;
          d = t0 + (BITC*i + BITC - 3)*CP + 1 - $time;
          #d s2 = tx;
          abort = rst_cnt != rc;
          if (s0 !== s1 || s2 !== s1) f.ok = 1'b0;
          if (i == 0 && s1 !== 1'b0) f.ok = 1'b0;
          if (i == 9 && s1 !== 1'b1) f.ok = 1'b0;
          if (i > 0 && i < 9) f.d[i-1] = s1;
        end
      end
      if (!abort) frames_q.push_back(f);
      mon_busy = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] v, input logic stop);
    rx = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (BITC) @(negedge clk);
    end
    rx = stop;
    repeat (BITC) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic load(input logic [7:0] cmd, input logic [7:0] v);
    send_byte(cmd, 1'b1);
    send_byte(v, 1'b1);
  endtask

  task automatic exec(input logic [7:0] e);
    exp_q.push_back(e);
    send_byte(8'h04, 1'b1);
  endtask

  task automatic check_frames(input string name);
    int n = 0;
    frame_t f;
    logic [7:0] e;
    while ((frames_q.size() < exp_q.size() || mon_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (frames_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no frame on tx, required data 0x%02h", name, e);
      end else begin
        f = frames_q.pop_front();
        if (f.d !== e || !f.ok) begin
          errors++;
          $display("FAIL %s: frame data 0x%02h framing_ok %0b, required 0x%02h framing_ok 1", name, f.d, f.ok, e);
        end
      end
    end
    checks++;
    if (frames_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d unexpected frames on tx, required 0", name, frames_q.size());
      frames_q.delete();
    end
  endtask

  task automatic test_reset;
    #5 reset = 1'b0;
    #100;
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: tx %b during reset, required 1", tx);
    end
    @(negedge clk) reset = 1'b1;
    repeat (400) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || started != 0) begin
      errors++;
      $display("FAIL reset_idle: tx %b frames %0d, required tx 1 frames 0", tx, started);
    end
  endtask

  task automatic test_add;
    int s;
    load(8'h01, 8'h05);
    load(8'h02, 8'h03);
    load(8'h03, 8'h20);
    s = started;
    exec(8'h08);
    checks++;
    if (started != s + 1) begin
      errors++;
      $display("FAIL add_latency: %0d frames begun by end of exec stop bit, required %0d", started - s, 1);
    end
    check_frames("add");
  endtask

  task automatic test_alu;
    load(8'h01, 8'h05);
    load(8'h02, 8'h03);
    load(8'h03, 8'h22); exec(8'h02);
    load(8'h03, 8'h27); exec(8'hF8);
    load(8'h03, 8'h24); exec(8'h01);
    load(8'h03, 8'h25); exec(8'h07);
    load(8'h03, 8'h26); exec(8'h06);
    load(8'h03, 8'h55); exec(8'h00);
    load(8'h01, 8'h03);
    load(8'h02, 8'h05);
    load(8'h03, 8'h22); exec(8'hFE);
    check_frames("alu");
  endtask

  task automatic test_shift;
    load(8'h01, 8'h80);
    load(8'h02, 8'h02);
    load(8'h03, 8'h03); exec(SH ? 8'hE0 : 8'h00);
    load(8'h03, 8'h02); exec(SH ? 8'h20 : 8'h00);
    load(8'h02, 8'h09);
    load(8'h03, 8'h03); exec(SH ? 8'hFF : 8'h00);
    load(8'h03, 8'h02); exec(8'h00);
    check_frames("shift");
  endtask

  task automatic test_errors;
    load(8'h01, 8'h10);
    load(8'h02, 8'h22);
    load(8'h03, 8'h20);
    exec(8'h32);
    check_frames("err_setup");
    send_byte(8'h7F, 1'b1);
    send_byte(8'h01, 1'b0);
    repeat (2*BITC) @(negedge clk);
    send_byte(8'h44, 1'b1);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (2*BITC) @(negedge clk);
    exec(8'h32);
    check_frames("err_recover");
  endtask

  task automatic test_back_to_back;
    load(8'h01, 8'h40);
    exec(8'h62);
    repeat (2*BITC) @(negedge clk);
    exec(8'h62);
    check_frames("back_to_back");
  endtask

  task automatic test_reset_mid;
    int s;
    load(8'h01, 8'h11);
    s = started;
    send_byte(8'h04, 1'b1);
    repeat (3*BITC) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || started != s + 1) begin
      errors++;
      $display("FAIL reset_mid_tx: tx %b frames begun %0d, required tx 1 frames begun 1", tx, started - s);
    end
    #100;
    @(negedge clk) reset = 1'b1;
    repeat (2*BITC) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || started != s + 1) begin
      errors++;
      $display("FAIL reset_mid_idle: tx %b frames begun %0d, required tx 1 frames begun 1", tx, started - s);
    end
    exec(8'h00);
    check_frames("reset_mid");
  endtask

  initial begin
    test_reset;
    test_add;
    test_alu;
    test_shift;
    test_errors;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
